// File: rtl/matriz_pkg.sv
// Shared definitions for the 5x7 matrix scanner: column count, priority modes
// and the glyph font (column patterns, active-high, bit 0 = top row).
package matriz_pkg;

  localparam int NCOL = 5;

  typedef enum logic [1:0] {
    ALT    = 2'b00,
    F_IE01 = 2'b01,
    F_IE02 = 2'b10,
    BLANK  = 2'b11
  } prio_e;

  // Index order: [code][column], column 0 is the leftmost column.
  localparam logic [6:0] GLYPH [8][5] = '{
    '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00},  // 0: blank
    '{7'h00, 7'h42, 7'h7F, 7'h40, 7'h00},  // 1
    '{7'h42, 7'h61, 7'h51, 7'h49, 7'h46},  // 2
    '{7'h21, 7'h41, 7'h45, 7'h4B, 7'h31},  // 3
    '{7'h18, 7'h14, 7'h12, 7'h7F, 7'h10},  // 4
    '{7'h27, 7'h45, 7'h45, 7'h45, 7'h39},  // 5
    '{7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30},  // 6
    '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F}   // 7: all on
  };

endpackage

// File: rtl/matriz_varredura_glyph_rom.sv
// Combinational glyph lookup: one 7-bit column pattern per (code, column).
// Column indices beyond the matrix width read as dark.
module glyph_rom
  import matriz_pkg::*;
(
  input  logic [2:0] code,
  input  logic [2:0] col,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = '0;
    case (col)
      3'd0: pattern = GLYPH[code][0];
      3'd1: pattern = GLYPH[code][1];
      3'd2: pattern = GLYPH[code][2];
      3'd3: pattern = GLYPH[code][3];
      3'd4: pattern = GLYPH[code][4];
      default: pattern = '0;
    endcase
  end

endmodule

// File: rtl/matriz_varredura.sv
// Time-multiplexed column scanner for the 5x7 LED matrix with frame-synchronous
// code updates and alternation between the IE01 and IE02 sources.
module matriz_varredura
  import matriz_pkg::*;
#(
  parameter int DIV         = 25000,
  parameter int HOLD_FRAMES = 200
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [2:0]      MAT_IE01,
  input  logic [2:0]      MAT_IE02,
  input  logic            UPD,
  input  logic [1:0]      PRIO_SEL,
  output logic            UPD_ACK,
  output logic [NCOL-1:0] MCOL,
  output logic [6:0]      MROW,
  output logic            SRC
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      col_q, col_d;
  logic [NCOL-1:0] mcol_q, mcol_d;
  logic [6:0]      mrow_q, mrow_d;
  logic            src_q, src_d;
  logic            ack_q, ack_d;
  logic [2:0]      pend01_q, pend01_d, pend02_q, pend02_d;
  logic            pend_vld_q, pend_vld_d;
  logic [2:0]      disp01_q, disp01_d, disp02_q, disp02_d;
  logic [FW-1:0]   frame_q, frame_d;
  prio_e           mode_q, mode_d;

  logic       tick, wrap, commit, blank;
  prio_e      prio;
  logic [2:0] rom_code;
  logic [6:0] rom_pat;

  assign prio     = prio_e'(PRIO_SEL);
  assign tick     = (presc_q == PW'(DIV - 1));
  assign wrap     = tick && (col_q == 3'(NCOL - 1));
  assign commit   = wrap && pend_vld_q;
  // The ROM looks at the post-edge source, code and column so rows and columns move together.
  assign rom_code = src_d ? disp02_d : disp01_d;

  glyph_rom u_glyph_rom (
    .code    (rom_code),
    .col     (col_d),
    .pattern (rom_pat)
  );

  always_comb begin
    presc_d    = tick ? '0 : presc_q + 1'b1;
    col_d      = col_q;
    mcol_d     = mcol_q;
    mrow_d     = mrow_q;
    src_d      = src_q;
    frame_d    = frame_q;
    mode_d     = mode_q;
    ack_d      = commit;
    disp01_d   = commit ? pend01_q : disp01_q;
    disp02_d   = commit ? pend02_q : disp02_q;
    pend01_d   = pend01_q;
    pend02_d   = pend02_q;
    pend_vld_d = pend_vld_q && !commit;
    blank      = 1'b0;

    // An update in the commit cycle re-arms pending after the old value is taken.
    if (UPD) begin
      pend01_d   = MAT_IE01;
      pend02_d   = MAT_IE02;
      pend_vld_d = 1'b1;
    end

    if (wrap) begin
      mode_d = prio;
      case (prio)
        F_IE01: begin src_d = 1'b0; frame_d = '0; end
        F_IE02: begin src_d = 1'b1; frame_d = '0; end
        ALT: begin
          if (frame_q == FW'(HOLD_FRAMES - 1)) begin
            frame_d = '0;
            src_d   = ~src_q;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (tick) begin
      col_d  = wrap ? 3'd0 : col_q + 3'd1;
      mcol_d = {{(NCOL-1){1'b0}}, 1'b1} << col_d;
      // Blank applies at once; leaving blank waits for the frame-boundary mode update.
      blank  = (prio == BLANK) || (mode_d == BLANK);
      mrow_d = blank ? 7'h7F : ~rom_pat;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      presc_q    <= '0;
      col_q      <= '0;
      mcol_q     <= {{(NCOL-1){1'b0}}, 1'b1};
      mrow_q     <= 7'h7F;
      src_q      <= 1'b0;
      ack_q      <= 1'b0;
      pend01_q   <= '0;
      pend02_q   <= '0;
      pend_vld_q <= 1'b0;
      disp01_q   <= '0;
      disp02_q   <= '0;
      frame_q    <= '0;
      mode_q     <= ALT;
    end else begin
      presc_q    <= presc_d;
      col_q      <= col_d;
      mcol_q     <= mcol_d;
      mrow_q     <= mrow_d;
      src_q      <= src_d;
      ack_q      <= ack_d;
      pend01_q   <= pend01_d;
      pend02_q   <= pend02_d;
      pend_vld_q <= pend_vld_d;
      disp01_q   <= disp01_d;
      disp02_q   <= disp02_d;
      frame_q    <= frame_d;
      mode_q     <= mode_d;
    end
  end

  assign UPD_ACK = ack_q;
  assign MCOL    = mcol_q;
  assign MROW    = mrow_q;
  assign SRC     = src_q;

endmodule

// File: doc/matriz_varredura.md
Name: matriz_varredura

Overview:
- Time-multiplexed column scanner for the 5x7 LED matrix.
- Consumes the 3-bit matrix codes produced for IE01 and IE02 and turns them into glyph bitmaps.
- Drives one column at a time instead of holding a single column statically high.
- Sits between the function encoders and the board matrix pins; adds refresh timing, frame-synchronous code update and IE alternation.

Parameters:
- DIV, 25000, clock cycles per column slot (50 MHz / 25000 = 2 kHz column rate, 400 Hz frame rate).
- HOLD_FRAMES, 200, frames a source stays displayed before alternating to the other IE.
- NCOL, 5, matrix columns (fixed at 5; present for clarity only).

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- MAT_IE01  in  3  matrix code requested by IE01.
- MAT_IE02  in  3  matrix code requested by IE02.
- UPD  in  1  one-cycle strobe: new codes are valid on MAT_IE01/MAT_IE02.
- PRIO_SEL  in  2  00 = alternate, 01 = force IE01, 10 = force IE02, 11 = blank.
- UPD_ACK  out  1  one-cycle pulse when pending codes are committed to the display buffer.
- MCOL  out  5  column enables, active-high, exactly one bit set while scanning.
- MROW  out  7  row drives, active-low (0 = LED on).
- SRC  out  1  source currently displayed (0 = IE01, 1 = IE02).

Behaviour:
- Reset (async assert, sync release):
  - MCOL = 5'b00001, MROW = 7'h7F, SRC = 0, UPD_ACK = 0.
  - Internal counters = 0; pending flag = 0; display buffer codes = 0 (blank glyph).
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - Asserts a one-cycle tick when it equals DIV-1.
- Column counter:
  - Advances 0→1→2→3→4→0 on each tick.
  - MCOL is one-hot of the counter, registered, and changes in the same cycle as the counter.
- Frame boundary: the tick on which the column wraps 4→0.
- MROW:
  - Registered; equals the active-low column slice of the glyph for the displayed code at the new column index.
  - Updates in the same cycle as MCOL, so no skew between row and column.
- Capture:
  - UPD latches MAT_IE01/MAT_IE02 into a pending register and sets the pending flag.
  - Repeated UPD before commit overwrites the pending codes (last write wins).
- Commit:
  - On a frame boundary with pending = 1, pending codes are copied to the display buffer and pending is cleared.
  - UPD_ACK pulses in that same cycle. The new glyph is first shown on column 0 of the new frame; no mid-frame tearing.
  - UPD coincident with the commit cycle: the commit takes the pre-existing pending value, the new UPD sets pending again, and it commits at the next frame.
- Alternation (PRIO_SEL = 00):
  - A frame counter counts 0..HOLD_FRAMES-1.
  - On wrap at a frame boundary, SRC toggles.
- Forced and blank modes:
  - PRIO_SEL = 01/10 forces SRC = 0/1 at the next frame boundary and holds the frame counter at 0.
  - PRIO_SEL = 11 drives MROW = 7'h7F from the next column tick onward. Scanning continues.
- Mode change: a PRIO_SEL change mid-frame takes effect only at a frame boundary (blank mode excepted, per above).
- Reset mid-frame: immediate return to the reset values; any pending update is discarded and no UPD_ACK is issued.
- Glyph lookup: pure combinational ROM, 8 codes x 5 columns x 7 rows.
  - Code 0 = all off.
  - Code 7 = all on.
  - Codes 1..6 = digits 1..6, bit 0 = top row.

Decomposition:
- Package matriz_pkg holds:
  - Glyph table constant GLYPH[8][5] of 7-bit column patterns (active-high, inverted at the output).
  - PRIO_SEL encodings ALT/F_IE01/F_IE02/BLANK.
  - NCOL.
- Sub-module glyph_rom: inputs code[2:0] and col[2:0], output row pattern[6:0]. Column indices 5..7 return 0.
- The scanner, capture/commit and alternation logic stay in matriz_varredura.

Test Plan (DIV = 4, HOLD_FRAMES = 2 override):
- Reset then idle 100 cycles:
  - MCOL sequence 00001,00010,00100,01000,10000 repeats, 4 cycles per column.
  - MROW = 7'h7F throughout.
  - UPD_ACK never asserts.
- UPD with IE01 = 7, IE02 = 0, PRIO_SEL = 01, issued mid-frame:
  - UPD_ACK pulses exactly at the next 4→0 wrap.
  - MROW = 7'h00 on all columns from that frame onward.
  - SRC = 0.
- Alternate mode, IE01 = 7, IE02 = 0:
  - SRC toggles every 2 frames (40 cycles).
  - MROW alternates between 7'h00 for 2 frames and 7'h7F for 2 frames.
- Two UPDs in one frame (codes 3 then 5 on IE01):
  - A single UPD_ACK is issued.
  - Displayed glyph = GLYPH[5].
  - Glyph 3 never appears.
- PRIO_SEL = 11 while IE01 = 7 is displayed:
  - MROW = 7'h7F from the next tick.
  - MCOL keeps scanning.
  - Returning to 01 restores 7'h00 at the next frame boundary.
- RST_n low mid-frame with pending = 1:
  - Outputs are at reset values within the same cycle (asynchronous).
  - After release, no UPD_ACK appears and the display stays blank.
